// File: rtl/cmd_fifo_if.sv
// Command handshake bundle: {cmd, addr, data} payload with valid/ready flow control.
// The master drives the payload and valid; the slave drives ready.
interface cmd_fifo_if #(
    parameter int ADDR_WD = 4,
    parameter int DATA_WD = 4
);
    logic               valid;
    logic               ready;
    logic               cmd;
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] data;

    modport master (output valid, cmd, addr, data, input ready);
    modport slave  (input valid, cmd, addr, data, output ready);
endinterface

// File: rtl/cmd_fifo.sv
// First-word-fall-through command queue ahead of the memory stage; head visible 1 cycle after push into empty.
// s.ready depends only on registered fullness (never on m.ready); no pass-through when full.
module cmd_fifo #(
    parameter int DATA_WD = 4,
    parameter int ADDR_WD = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_WD  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    cmd_fifo_if.slave         s,
    cmd_fifo_if.master        m,
    output logic [CNT_WD-1:0] count
);
    localparam int IDX_WD = CNT_WD - 1;
    localparam int ENT_WD = 1 + ADDR_WD + DATA_WD;

    logic [ENT_WD-1:0] r_mem [DEPTH];
    logic [CNT_WD-1:0] r_wr_ptr;
    logic [CNT_WD-1:0] r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [ENT_WD-1:0] w_head;

    // The extra MSB on each pointer distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_WD-1:0] == r_rd_ptr[IDX_WD-1:0]) &&
                     (r_wr_ptr[IDX_WD] != r_rd_ptr[IDX_WD]);

    assign s.ready = !w_full && !rst;
    assign m.valid = !w_empty;

    assign w_push = s.valid && s.ready;
    assign w_pop  = m.valid && m.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[IDX_WD-1:0]] <= {s.cmd, s.addr, s.data};
    end

    // Masking on empty keeps stale storage off the bus, including right after reset.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[IDX_WD-1:0]];
    assign {m.cmd, m.addr, m.data} = w_head;

    assign count = r_wr_ptr - r_rd_ptr;
endmodule

// File: tb/tb_cmd_fifo.sv
// Directed plus random stimulus for cmd_fifo; a negedge monitor checks against an occupancy model and expected-entry queue.
module tb_cmd_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;

    cmd_fifo_if #(.ADDR_WD(4), .DATA_WD(4)) s_if ();
    cmd_fifo_if #(.ADDR_WD(4), .DATA_WD(4)) m_if ();

    cmd_fifo #(.DATA_WD(4), .ADDR_WD(4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .s     (s_if),
        .m     (m_if),
        .count (count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int head();
        return {m_if.cmd, m_if.addr, m_if.data};
    endfunction

    // Scoreboard: entries accepted by the model, popped and compared when the model says a pop occurs.
    int       exp_q[$];
    int       mdl_cnt  = 0;
    bit       hold_vld = 0;
    int       held     = 0;

    always @(negedge clk) begin
        bit mdl_push;
        bit mdl_pop;
        if (rst) begin
            exp_q.delete();
            mdl_cnt  = 0;
            hold_vld = 0;
            chk("rst_s_ready", int'(s_if.ready), 0);
            chk("rst_m_valid", int'(m_if.valid), 0);
            chk("rst_payload", head(), 0);
            chk("rst_count", int'(count), 0);
        end else begin
            chk("count", int'(count), mdl_cnt);
            chk("s_ready", int'(s_if.ready), int'(mdl_cnt < DEPTH));
            chk("m_valid", int'(m_if.valid), int'(mdl_cnt != 0));
            if (mdl_cnt == 0) chk("idle_payload", head(), 0);
            if (hold_vld) chk("stable_payload", head(), held);
            mdl_push = s_if.valid && (mdl_cnt < DEPTH);
            mdl_pop  = m_if.ready && (mdl_cnt != 0);
            if (mdl_pop) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_order", head(), exp_q.pop_front());
            end
            if (mdl_push) exp_q.push_back({s_if.cmd, s_if.addr, s_if.data});
            hold_vld = (mdl_cnt != 0) && !m_if.ready;
            held     = head();
            mdl_cnt  = mdl_cnt + int'(mdl_push) - int'(mdl_pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit c, input logic [3:0] a, input logic [3:0] d);
        s_if.valid = v;
        s_if.cmd   = c;
        s_if.addr  = a;
        s_if.data  = d;
    endtask

    initial begin
        drive(0, 0, 4'h0, 4'h0);
        m_if.ready = 1'b0;

        // Reset and idle
        #1;
        chk("in_rst_s_ready", int'(s_if.ready), 0);
        chk("in_rst_count", int'(count), 0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", int'(s_if.ready), 1);
        chk("post_rst_m_valid", int'(m_if.valid), 0);
        chk("post_rst_count", int'(count), 0);

        // Write then read with m_ready low
        drive(1, 1, 4'h3, 4'hA);
        step();
        chk("t2_count1", int'(count), 1);
        chk("t2_m_valid", int'(m_if.valid), 1);
        chk("t2_head_w", head(), 9'h13A);
        drive(1, 0, 4'h3, 4'h0);
        step();
        chk("t2_count2", int'(count), 2);
        chk("t2_head_held", head(), 9'h13A);
        drive(0, 0, 4'h0, 4'h0);
        m_if.ready = 1'b1;
        step();
        chk("t2_head_r", head(), 9'h030);
        chk("t2_m_valid_r", int'(m_if.valid), 1);
        step();
        chk("t2_drained_valid", int'(m_if.valid), 0);
        chk("t2_drained_count", int'(count), 0);
        m_if.ready = 1'b0;

        // Fill to full, then one pop lets the stalled command in
        for (int a = 0; a < 4; a++) begin
            drive(1, a[0], 4'(a), 4'(a));
            step();
            chk("t3_fill_count", int'(count), a + 1);
        end
        chk("t3_full_s_ready", int'(s_if.ready), 0);
        drive(1, 0, 4'h4, 4'h4);
        step();
        chk("t3_stall_count", int'(count), 4);
        chk("t3_stall_head", int'(m_if.addr), 0);
        m_if.ready = 1'b1;
        step();
        m_if.ready = 1'b0;
        chk("t3_after_pop_s_ready", int'(s_if.ready), 1);
        chk("t3_after_pop_count", int'(count), 3);
        step();
        drive(0, 0, 4'h0, 4'h0);
        chk("t3_refill_count", int'(count), 4);
        m_if.ready = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            chk("t3_order", int'(m_if.addr), a);
            step();
        end
        chk("t3_empty_count", int'(count), 0);
        m_if.ready = 1'b0;

        // Simultaneous push and pop across pointer wrap, starting at count 2
        drive(1, 1, 4'h8, 4'h1);
        step();
        drive(1, 1, 4'h9, 4'h2);
        step();
        m_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 4'(10 + i), 4'(i));
            step();
            chk("t4_count", int'(count), 2);
            chk("t4_head_addr", int'(m_if.addr), (9 + i) & 15);
        end
        drive(0, 0, 4'h0, 4'h0);
        repeat (2) step();
        chk("t4_drained", int'(count), 0);
        m_if.ready = 1'b0;

        // Asynchronous reset mid-operation
        for (int a = 1; a <= 3; a++) begin
            drive(1, 1, 4'(a), 4'hF);
            step();
        end
        drive(0, 0, 4'h0, 4'h0);
        chk("t5_pre_count", int'(count), 3);
        chk("t5_pre_valid", int'(m_if.valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", int'(m_if.valid), 0);
        chk("t5_async_payload", head(), 0);
        chk("t5_async_count", int'(count), 0);
        chk("t5_async_s_ready", int'(s_if.ready), 0);
        repeat (2) step();
        rst = 1'b0;
        drive(1, 1, 4'h7, 4'h5);
        step();
        drive(0, 0, 4'h0, 4'h0);
        chk("t5_new_count", int'(count), 1);
        chk("t5_new_head", head(), 9'h175);
        m_if.ready = 1'b1;
        step();
        chk("t5_only_entry", int'(m_if.valid), 0);
        m_if.ready = 1'b0;

        // Random valid/ready; the monitor does the checking
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            m_if.ready = 1'($urandom_range(0, 1));
            step();
        end
        drive(0, 0, 4'h0, 4'h0);
        m_if.ready = 1'b1;
        repeat (DEPTH + 1) step();
        chk("final_count", int'(count), 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
